// File: rtl/floating_point_compare_buffer.sv
// Result buffer between the FP comparator and writeback: a DEPTH-entry FIFO of
// {result, NV, tag} plus the sticky NV flag that retires with each popped entry.
module floating_point_compare_buffer #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [31:0]          result_i,
  input  logic                 invalid_op_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 data_valid_i,
  output logic                 full_o,
  output logic [31:0]          result_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 invalid_op_o,
  output logic                 data_valid_o,
  input  logic                 ready_i,
  input  logic                 clear_flags_i,
  output logic                 fflags_nv_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  // Handshake: an entry moves into the buffer on data_valid_i & !full_o, and
  // out of it on data_valid_o & ready_i; flush_i or rst_i cancels both moves.

  logic [31:0]          res_mem_q [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem_q [DEPTH];
  logic [DEPTH-1:0]     nv_mem_q;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fflags_q, fflags_d;
  logic          push, pop;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          unused_ptr_msb;

  // Pointers wrap at DEPTH-1, so their top bit never sets.
  assign wr_idx         = wr_ptr_q[AW-1:0];
  assign rd_idx         = rd_ptr_q[AW-1:0];
  assign unused_ptr_msb = wr_ptr_q[AW] ^ rd_ptr_q[AW];

  assign full_o       = (count_q == DEPTH_C);
  assign data_valid_o = (count_q != '0);
  assign result_o     = res_mem_q[rd_idx];
  assign tag_o        = tag_mem_q[rd_idx];
  assign invalid_op_o = nv_mem_q[rd_idx];
  assign fflags_nv_o  = fflags_q;

  always_comb begin
    push     = data_valid_i && !full_o && !flush_i;
    pop      = data_valid_o && ready_i && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fflags_d = fflags_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + CW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + CW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A retiring NV wins over a same-cycle CSR clear.
    if (pop && nv_mem_q[rd_idx]) begin
      fflags_d = 1'b1;
    end else if (clear_flags_i) begin
      fflags_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= 1'b0;
      nv_mem_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      if (push) begin
        res_mem_q[wr_idx] <= result_i;
        tag_mem_q[wr_idx] <= tag_i;
        nv_mem_q[wr_idx]  <= invalid_op_i;
      end
    end
  end

  // Flags upstream offering a result while the buffer is full (it is dropped).
  cover property (@(posedge clk_i) disable iff (rst_i) (data_valid_i && full_o));

endmodule

// File: tb/tb_floating_point_compare_buffer.sv
// Bench for floating_point_compare_buffer: directed scenarios plus a negedge
// scoreboard that tracks occupancy, head entry and the sticky NV flag.
module tb_floating_point_compare_buffer;

  localparam int DEPTH = 4;
  localparam int TW    = 6;
  localparam int EW    = 32 + 1 + TW;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, invalid_op_i, data_valid_i, ready_i, clear_flags_i;
  logic [31:0]   result_i;
  logic [TW-1:0] tag_i;
  logic          full_o, invalid_op_o, data_valid_o, fflags_nv_o;
  logic [31:0]   result_o;
  logic [TW-1:0] tag_o;

  logic [EW-1:0] exp_q[$];
  logic          exp_nv = 1'b0;
  logic          mon_en = 1'b0;
  int            n_cmp  = 0;
  int            n_err  = 0;

  floating_point_compare_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .result_i(result_i),
    .invalid_op_i(invalid_op_i), .tag_i(tag_i), .data_valid_i(data_valid_i),
    .full_o(full_o), .result_o(result_o), .tag_o(tag_o),
    .invalid_op_o(invalid_op_o), .data_valid_o(data_valid_o), .ready_i(ready_i),
    .clear_flags_i(clear_flags_i), .fflags_nv_o(fflags_nv_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: checks the DUT at negedge, then applies this cycle's inputs to the model.
  always @(negedge clk) begin : monitor
    int            sz;
    logic          pop_m;
    logic [EW-1:0] head;
    if (mon_en) begin
      sz = exp_q.size();
      n_cmp++;
      if (data_valid_o !== (sz != 0)) begin
        n_err++; $display("FAIL mon_valid: got %b want %b", data_valid_o, (sz != 0));
      end
      n_cmp++;
      if (full_o !== (sz == DEPTH)) begin
        n_err++; $display("FAIL mon_full: got %b want %b", full_o, (sz == DEPTH));
      end
      n_cmp++;
      if (fflags_nv_o !== exp_nv) begin
        n_err++; $display("FAIL mon_fflags: got %b want %b", fflags_nv_o, exp_nv);
      end
      if (sz != 0) begin
        n_cmp++;
        if ({result_o, invalid_op_o, tag_o} !== exp_q[0]) begin
          n_err++;
          $display("FAIL mon_head: got %h/%b/%0d want %h/%b/%0d", result_o, invalid_op_o,
                   tag_o, exp_q[0][EW-1:TW+1], exp_q[0][TW], exp_q[0][TW-1:0]);
        end
      end
      pop_m = (sz != 0) && ready_i && !flush_i;
      if (rst_i) begin
        exp_q.delete();
        exp_nv = 1'b0;
      end else if (flush_i) begin
        exp_q.delete();
        if (clear_flags_i) exp_nv = 1'b0;
      end else begin
        if (pop_m) begin
          head = exp_q.pop_front();
          if (head[TW]) exp_nv = 1'b1;
          else if (clear_flags_i) exp_nv = 1'b0;
        end else if (clear_flags_i) begin
          exp_nv = 1'b0;
        end
        if (data_valid_i && sz < DEPTH) exp_q.push_back({result_i, invalid_op_i, tag_i});
      end
    end
  end

  // Driver: apply one cycle of inputs just after a posedge, return just after the next.
  task automatic drive(input logic v, input logic [31:0] r, input logic nv,
                       input logic [TW-1:0] t, input logic rdy, input logic clr,
                       input logic fl);
    data_valid_i  = v;
    result_i      = r;
    invalid_op_i  = nv;
    tag_i         = t;
    ready_i       = rdy;
    clear_flags_i = clr;
    flush_i       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", data_valid_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full_o); end
    n_cmp++; if (result_o !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h want 0", result_o); end
    n_cmp++; if (tag_o !== '0) begin n_err++; $display("FAIL rst_tag: got %0d want 0", tag_o); end
    n_cmp++; if (invalid_op_o !== 1'b0) begin n_err++; $display("FAIL rst_nv: got %b want 0", invalid_op_o); end
    n_cmp++; if (fflags_nv_o !== 1'b0) begin n_err++; $display("FAIL rst_fflags: got %b want 0", fflags_nv_o); end
  endtask

  task automatic test_single;
    drive(1'b1, 32'h3F80_0000, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (data_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", data_valid_o); end
    n_cmp++; if (result_o !== 32'h3F80_0000) begin n_err++; $display("FAIL single_result: got %h want 3f800000", result_o); end
    n_cmp++; if (tag_o !== 6'd5) begin n_err++; $display("FAIL single_tag: got %0d want 5", tag_o); end
    drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL single_gone: got %b want 0", data_valid_o); end
  endtask

  task automatic test_full;
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'h4000_0000 + i, 1'b0, TW'(i), 1'b0, 1'b0, 1'b0);
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL full_set: got %b want 1", full_o); end
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL full_hold: got %b want 1", full_o); end
    n_cmp++; if (tag_o !== 6'd1) begin n_err++; $display("FAIL full_head: got %0d want 1", tag_o); end
    drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL full_drop: got %b want 0", full_o); end
    n_cmp++; if (tag_o !== 6'd2) begin n_err++; $display("FAIL full_next: got %0d want 2", tag_o); end
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL full_drain: got %b want 0", data_valid_o); end
  endtask

  task automatic test_wrap;
    int   pushed = 0;
    logic v;
    for (int c = 0; c < 300 && pushed < 10; c++) begin
      v = (exp_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      if (v) pushed++;
      drive(v, $urandom, 1'b0, TW'(pushed), $urandom_range(0, 1) == 1, 1'b0, 1'b0);
    end
    n_cmp++; if (pushed != 10) begin n_err++; $display("FAIL wrap_timeout: got %0d want 10", pushed); end
    for (int c = 0; c < 20 && data_valid_o === 1'b1; c++) drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL wrap_drain: got %b want 0", data_valid_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pat [6];
    pat[0] = 32'h7FC0_0000; pat[1] = 32'h8000_0000; pat[2] = 32'h7F80_0000;
    pat[3] = 32'hFF80_0000; pat[4] = 32'h0000_0001; pat[5] = 32'h0000_0000;
    for (int i = 0; i < 6; i++) drive(1'b1, pat[i], 1'b0, TW'(20 + i), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", data_valid_o); end
  endtask

  task automatic test_flags;
    drive(1'b1, 32'h7FC0_0000, 1'b1, 6'd11, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (fflags_nv_o !== 1'b1) begin n_err++; $display("FAIL flags_set: got %b want 1", fflags_nv_o); end
    drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (fflags_nv_o !== 1'b0) begin n_err++; $display("FAIL flags_clear: got %b want 0", fflags_nv_o); end
  endtask

  task automatic test_flush;
    drive(1'b1, 32'h7FA0_0000, 1'b1, 6'd12, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h7FA0_0001, 1'b1, 6'd13, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h3F00_0000, 1'b0, 6'd14, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h3E00_0000, 1'b0, 6'd15, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h1234_5678, 1'b0, 6'd16, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", data_valid_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b want 0", full_o); end
    n_cmp++; if (fflags_nv_o !== 1'b1) begin n_err++; $display("FAIL flush_fflags: got %b want 1", fflags_nv_o); end
    drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 32'hC000_0000, 1'b1, 6'd30, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC040_0000, 1'b0, 6'd31, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 6'd63, 1'b1, 1'b0, 1'b0);
    rst_i = 1'b0;
    n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", data_valid_o); end
    n_cmp++; if (result_o !== 32'h0) begin n_err++; $display("FAIL mid_result: got %h want 0", result_o); end
    n_cmp++; if (tag_o !== '0) begin n_err++; $display("FAIL mid_tag: got %0d want 0", tag_o); end
    n_cmp++; if (invalid_op_o !== 1'b0) begin n_err++; $display("FAIL mid_nv: got %b want 0", invalid_op_o); end
    n_cmp++; if (fflags_nv_o !== 1'b0) begin n_err++; $display("FAIL mid_fflags: got %b want 0", fflags_nv_o); end
    drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; result_i = '0; invalid_op_i = 1'b0;
    tag_i = '0; data_valid_i = 1'b0; ready_i = 1'b0; clear_flags_i = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_full;
    test_wrap;
    test_back_to_back;
    test_flags;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/floating_point_compare_buffer.md
FLOATING_POINT_COMPARE_BUFFER -- requirements
Module: floating_point_compare_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, >= 2.
REQ-002 SHALL have parameter TAG_WIDTH, default 6, width of the instruction tag carried alongside each result.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush_i  input  1  discard all buffered entries (pipeline flush).
REQ-006 SHALL have port result_i  input  32  float32_t result from the comparator (flag word or selected operand).
REQ-007 SHALL have port invalid_op_i  input  1  comparator NV exception for this result.
REQ-008 SHALL have port tag_i  input  TAG_WIDTH  instruction tag of this result.
REQ-009 SHALL have port data_valid_i  input  1  result_i/invalid_op_i/tag_i valid this cycle.
REQ-010 SHALL have port full_o  output  1  buffer full; upstream SHALL NOT assert data_valid_i while high.
REQ-011 SHALL have port result_o  output  32  head-entry result.
REQ-012 SHALL have port tag_o  output  TAG_WIDTH  head-entry tag.
REQ-013 SHALL have port invalid_op_o  output  1  head-entry NV exception.
REQ-014 SHALL have port data_valid_o  output  1  head entry valid for writeback.
REQ-015 SHALL have port ready_i  input  1  writeback accepts head entry this cycle.
REQ-016 SHALL have port clear_flags_i  input  1  clear sticky NV flag (CSR write to fflags).
REQ-017 SHALL have port fflags_nv_o  output  1  sticky accumulated NV flag.

Function
REQ-018 SHALL implement a DEPTH-entry circular FIFO, entry = {result, invalid_op, tag}, with write pointer, read pointer and occupancy counter of width $clog2(DEPTH)+1.
REQ-019 Push SHALL occur when data_valid_i & !full_o & !flush_i; entry written at write pointer, pointer increments.
REQ-020 data_valid_i while full_o is high SHALL be ignored (no state change); a verification assertion SHALL flag it.
REQ-021 Pop SHALL occur when data_valid_o & ready_i & !flush_i; read pointer increments.
REQ-022 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; when full, push is still refused even if pop occurs the same cycle (full_o derives from registered occupancy only).
REQ-024 No bypass: a result pushed into an empty buffer SHALL appear on data_valid_o/result_o exactly one cycle later (latency 1).
REQ-025 data_valid_o SHALL equal (occupancy != 0); full_o SHALL equal (occupancy == DEPTH); both purely registered-state decodes.
REQ-026 result_o/tag_o/invalid_op_o SHALL be the entry at the read pointer; value when data_valid_o is low is don't-care but SHALL NOT be X after reset (storage reset to zero).
REQ-027 Head outputs SHALL remain stable while data_valid_o & !ready_i (back-pressure hold).
REQ-028 fflags_nv_o SHALL be set on the cycle after a pop whose entry has invalid_op=1 (flags retire with the instruction, not on entry).
REQ-029 fflags_nv_o SHALL clear the cycle after clear_flags_i; simultaneous clear_flags_i and a retiring NV pop SHALL leave it set.
REQ-030 flush_i SHALL, next cycle, zero both pointers and occupancy; concurrent push and pop are discarded; fflags_nv_o unaffected.
REQ-031 flush_i and rst_i together: reset takes priority (identical result except fflags_nv_o cleared).

Reset
REQ-032 On rst_i high at a rising edge: pointers, occupancy, storage and fflags_nv_o SHALL become 0; thus data_valid_o=0, full_o=0, result_o=0, tag_o=0, invalid_op_o=0.
REQ-033 Reset asserted mid-operation SHALL drop all buffered entries; pushes/pops in that cycle are discarded.

Verification
REQ-034 Reset, then push result 0x3F800000 tag 5 with ready_i=1 -> data_valid_o=1, result_o=0x3F800000, tag_o=5 exactly one cycle later, then 0.
REQ-035 ready_i=0, push tags 1..4 -> full_o=1 after fourth push; fifth data_valid_i ignored; raise ready_i -> tags 1,2,3,4 out in order, full_o drops after first pop.
REQ-036 Fill/drain 10 entries with ready_i random -> pointer wrap, no loss, order preserved.
REQ-037 Pop entry with invalid_op=1 while clear_flags_i=1 -> fflags_nv_o=1; next cycle clear_flags_i alone -> fflags_nv_o=0.
REQ-038 Three entries buffered (one with NV), assert flush_i with data_valid_i=1 -> next cycle data_valid_o=0, full_o=0, fflags_nv_o unchanged.
REQ-039 Assert rst_i with 2 entries and fflags_nv_o=1 -> next cycle all outputs 0.
